// File: rtl/shared_mem_arbiter.sv
// ============================================================================
// shared_mem_arbiter : round-robin access arbiter for the shared data RAM
// Rev 1.0
// ============================================================================
`default_nettype none

module shared_mem_arbiter #(
    parameter int CORES      = 4,
    parameter int WIDTH      = 12,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rstN,
    input  logic [CORES-1:0]            req,
    input  logic [CORES-1:0]            wr,
    input  logic [CORES*ADDR_WIDTH-1:0] addrIn,
    input  logic [CORES*WIDTH-1:0]      dataIn,
    output logic [CORES-1:0]            grant,
    output logic [CORES-1:0]            rdValid,
    output logic [WIDTH-1:0]            rdData,
    output logic                        ramWrEn,
    output logic [ADDR_WIDTH-1:0]       ramAddr,
    output logic [WIDTH-1:0]            ramDataIn,
    input  logic [WIDTH-1:0]            ramDataOut
);

    localparam int               IDX_W  = (CORES > 1) ? $clog2(CORES) : 1;
    localparam logic [IDX_W-1:0] C_LAST = IDX_W'(CORES - 1);
    localparam logic [CORES-1:0] C_ONE  = CORES'(1);

    logic [IDX_W-1:0] r_ptr;
    logic             r_rd_pend;
    logic [IDX_W-1:0] r_rd_idx;

    logic             w_found;
    logic [IDX_W-1:0] w_gnt_idx;
    logic [IDX_W-1:0] w_cand;

    // Walk CORES candidates starting at r_ptr; wrap is explicit so that
    // non-power-of-two core counts never index past the last core.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_cand    = r_ptr;
        for (int off = 0; off < CORES; off++) begin
            if (!w_found && req[w_cand]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_cand;
            end
            w_cand = (w_cand == C_LAST) ? '0 : w_cand + 1'b1;
        end
        w_found = w_found & rstN;
    end

    always_comb begin
        grant     = '0;
        ramWrEn   = 1'b0;
        ramAddr   = '0;
        ramDataIn = '0;
        if (w_found) begin
            grant     = C_ONE << w_gnt_idx;
            ramWrEn   = wr[w_gnt_idx];
            ramAddr   = addrIn[w_gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
            ramDataIn = dataIn[w_gnt_idx*WIDTH +: WIDTH];
        end
    end

    // Read data is returned the cycle after the grant; reset kills it at once.
    always_comb begin
        rdValid = '0;
        rdData  = '0;
        if (r_rd_pend && rstN) begin
            rdValid = C_ONE << r_rd_idx;
            rdData  = ramDataOut;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_ptr     <= '0;
            r_rd_pend <= 1'b0;
            r_rd_idx  <= '0;
        end else begin
            if (w_found) begin
                r_ptr <= (w_gnt_idx == C_LAST) ? '0 : w_gnt_idx + 1'b1;
            end
            r_rd_pend <= w_found & ~wr[w_gnt_idx];
            r_rd_idx  <= w_gnt_idx;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_shared_mem_arbiter.sv
// ============================================================================
// tb_shared_mem_arbiter : directed bench with a cycle-level reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_shared_mem_arbiter;

    localparam int CORES = 4;
    localparam int WIDTH = 12;
    localparam int AW    = 8;

    logic                  clk = 1'b0;
    logic                  rstN;
    logic [CORES-1:0]      req;
    logic [CORES-1:0]      wr;
    logic [CORES*AW-1:0]   addrIn;
    logic [CORES*WIDTH-1:0] dataIn;
    logic [CORES-1:0]      grant;
    logic [CORES-1:0]      rdValid;
    logic [WIDTH-1:0]      rdData;
    logic                  ramWrEn;
    logic [AW-1:0]         ramAddr;
    logic [WIDTH-1:0]      ramDataIn;
    logic [WIDTH-1:0]      ramDataOut;

    int errors = 0;
    int checks = 0;

    shared_mem_arbiter #(.CORES(CORES), .WIDTH(WIDTH), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rstN       (rstN),
        .req        (req),
        .wr         (wr),
        .addrIn     (addrIn),
        .dataIn     (dataIn),
        .grant      (grant),
        .rdValid    (rdValid),
        .rdData     (rdData),
        .ramWrEn    (ramWrEn),
        .ramAddr    (ramAddr),
        .ramDataIn  (ramDataIn),
        .ramDataOut (ramDataOut)
    );

    always #5 clk = ~clk;

    // Environment RAM: single port, registered read address.
    logic [WIDTH-1:0] ram [0:255];
    logic [AW-1:0]    ram_addr_q = '0;
    always @(posedge clk) begin
        if (ramWrEn) ram[ramAddr] <= ramDataIn;
        ram_addr_q <= ramAddr;
    end
    assign ramDataOut = ram[ram_addr_q];

    // Reference model: pointer, pending read and a shadow of memory contents.
    int               m_ptr = 0;
    bit               m_pend = 0;
    int               m_pend_core = 0;
    int               m_pend_addr = 0;
    logic [WIDTH-1:0] shadow [0:255];

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]    = WIDTH'(i * 37 + 5);
            shadow[i] = WIDTH'(i * 37 + 5);
        end
    end

    function automatic int model_grant();
        if (rstN !== 1'b1) return -1;
        for (int o = 0; o < CORES; o++) begin
            if (req[(m_ptr + o) % CORES]) return (m_ptr + o) % CORES;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        int g;
        g = model_grant();
        if (rstN !== 1'b1) begin
            m_ptr  <= 0;
            m_pend <= 0;
        end else if (g >= 0) begin
            m_ptr       <= (g + 1) % CORES;
            m_pend      <= !wr[g];
            m_pend_core <= g;
            m_pend_addr <= int'(addrIn[g*AW +: AW]);
            if (wr[g]) shadow[addrIn[g*AW +: AW]] <= dataIn[g*WIDTH +: WIDTH];
        end else begin
            m_pend <= 0;
        end
    end

    always @(negedge clk) begin
        int               g;
        logic [CORES-1:0] eg, ev;
        logic             ew;
        logic [AW-1:0]    ea;
        logic [WIDTH-1:0] ed, er;
        g  = model_grant();
        eg = '0; ew = 1'b0; ea = '0; ed = '0; ev = '0; er = '0;
        if (g >= 0) begin
            eg[g] = 1'b1;
            ew    = wr[g];
            ea    = addrIn[g*AW +: AW];
            ed    = dataIn[g*WIDTH +: WIDTH];
        end
        if (m_pend && rstN === 1'b1) begin
            ev[m_pend_core] = 1'b1;
            er = shadow[m_pend_addr];
        end
        chk("grant",     32'(grant),     32'(eg));
        chk("ramWrEn",   32'(ramWrEn),   32'(ew));
        chk("ramAddr",   32'(ramAddr),   32'(ea));
        chk("ramDataIn", 32'(ramDataIn), 32'(ed));
        chk("rdValid",   32'(rdValid),   32'(ev));
        chk("rdData",    32'(rdData),    32'(er));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input int k, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        addrIn[k*AW +: AW]       = a;
        dataIn[k*WIDTH +: WIDTH] = d;
    endtask

    int seq [4] = '{3, 1, 3, 1};
    int core0_wait;

    initial begin
        rstN = 1'b0; req = 4'hF; wr = 4'h0; addrIn = '0; dataIn = '0;
        for (int k = 0; k < CORES; k++) set_core(k, AW'(8'h20 + k), WIDTH'(k));

        // Reset with everyone requesting
        tick(); tick();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_rdvalid", 32'(rdValid), 32'h0);
        rstN = 1'b1; #1;
        chk("first_grant", 32'(grant), 32'b0001);
        tick();
        req = 4'h0;
        tick();

        // Single write then read by core 2 (ptr is 1 here)
        req = 4'b0100; wr = 4'b0100; set_core(2, 8'h10, 12'hABC); #1;
        chk("wr_grant2", 32'(grant), 32'b0100);
        chk("wr_en", 32'(ramWrEn), 32'h1);
        tick();
        wr = 4'b0000;
        tick();
        req = 4'h0; #1;
        chk("rd_valid2", 32'(rdValid), 32'b0100);
        chk("rd_data2", 32'(rdData), 32'hABC);

        // Core 3 access to bring ptr back to 0, then full contention
        req = 4'b1000; tick();
        req = 4'hF; wr = 4'h0;
        for (int k = 0; k < CORES; k++) set_core(k, AW'(8'h40 + k), '0);
        for (int i = 0; i < CORES; i++) begin
            #1;
            chk("contend_order", 32'(grant), 32'(1 << i));
            tick();
            req[i] = 1'b0;
        end
        #1;
        chk("contend_last_rdv", 32'(rdValid), 32'b1000);

        // Core 1 access leaves ptr at 2, then 1 and 3 compete
        req = 4'b0010; tick();
        req = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("fair_seq", 32'(grant), 32'(1 << seq[i]));
            tick();
        end
        req[0] = 1'b1;
        core0_wait = 0;
        while (grant[0] !== 1'b1 && core0_wait < CORES) begin
            tick();
            core0_wait++;
        end
        chk("core0_within_bound", 32'(grant[0]), 32'h1);
        tick();
        req = 4'h0;
        tick();

        // Write to 0xFF then immediate read of 0xFF by another core
        req = 4'b0001; wr = 4'b0001; set_core(0, 8'hFF, 12'h5A5); tick();
        req = 4'b0010; wr = 4'b0000; set_core(1, 8'hFF, 12'h000); tick();
        req = 4'h0; #1;
        chk("hazard_rdv", 32'(rdValid), 32'b0010);
        chk("hazard_data", 32'(rdData), 32'h5A5);

        // Reset right after a read grant to core 3
        req = 4'b1000; wr = 4'b0000; set_core(3, 8'h33, 12'h000); tick();
        rstN = 1'b0; req = 4'hF; wr = 4'hF; #1;
        chk("midrst_rdv", 32'(rdValid), 32'h0);
        chk("midrst_wren", 32'(ramWrEn), 32'h0);
        tick();
        chk("midrst_rdv2", 32'(rdValid), 32'h0);
        wr = 4'h0; rstN = 1'b1; #1;
        chk("post_rst_grant", 32'(grant), 32'b0001);
        chk("post_rst_rdv", 32'(rdValid), 32'h0);
        tick();
        req = 4'h0;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
